// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - PS/2 key event FIFO with held-key bitmap for clk_sys
module ps2_key_fifo #(
    parameter int DEPTH  = 16,  // power of two, minimum 2
    parameter int ADDR_W = 4    // log2(DEPTH)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [10:0]       ps2_key,
    input  logic              rd,
    output logic [9:0]        dout,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr,
    input  logic [8:0]        query_code,
    output logic              query_down
);

    localparam logic [ADDR_W:0]   LP_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_PTR_ONE = ADDR_W'(1);

    // Storage and state
    logic [9:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_last_toggle;
    logic [511:0]      r_bitmap;
    logic              r_query_down;

    logic w_event;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Event/occupancy decode; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        w_event = (ps2_key[10] != r_last_toggle);
        w_empty = (r_count == '0);
        w_full  = (r_count == LP_DEPTH);
        w_pop   = rd && !w_empty;
        w_push  = w_event && (!w_full || w_pop);
        w_drop  = w_event && w_full && !w_pop;
    end

    // Toggle history tracks the strobe every edge, including reset, so reset exit is quiet
    always_ff @(posedge clk_sys) begin
        r_last_toggle <= ps2_key[10];
    end

    // Entry storage; not reset because dout is masked while empty
    always_ff @(posedge clk_sys) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= ps2_key[9:0];
        end
    end

    // Pointers and occupancy count; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle wins over the clear
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Held-key bitmap follows every event, even ones the FIFO had to drop
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bitmap <= '0;
        end else if (w_event) begin
            r_bitmap[ps2_key[8:0]] <= ps2_key[9];
        end
    end

    // Registered lookup; reads the pre-update bitmap, so same-cycle writes show a cycle later
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_query_down <= 1'b0;
        end else begin
            r_query_down <= r_bitmap[query_code];
        end
    end

    // Output mapping; head entry falls through, zero when nothing is queued
    always_comb begin
        dout       = w_empty ? 10'h000 : r_mem[r_rd_ptr];
        empty      = w_empty;
        count      = r_count;
        overflow   = r_overflow;
        query_down = r_query_down;
    end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb/tb_ps2_key_fifo.sv - scoreboard bench for ps2_key_fifo against a queue model
module tb_ps2_key_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic [10:0]     ps2_key;
    logic            rd;
    logic [9:0]      dout;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            ovf_clr;
    logic [8:0]      query_code;
    logic            query_down;

    ps2_key_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .rd         (rd),
        .dout       (dout),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .query_code (query_code),
        .query_down (query_down)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the queue as a plain queue, held keys as an array
    logic [9:0] model_q[$];
    logic [9:0] exp_q[$];
    bit         m_bm [512];
    bit         m_ovf;
    bit         m_qd;
    bit         tog;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop must present the scoreboard's next entry
    always @(negedge clk_sys) begin
        if (!reset && rd && !empty) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got 0x%0h expected no pop", dout);
            end else begin
                chk("pop_data", int'(dout), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus: check present state, drive inputs, advance the model
    task automatic step(input bit ev, input logic [9:0] data, input bit r_rd,
                        input bit clr, input logic [8:0] qc, input bit rst);
        int  sz;
        bit  full;
        bit  pop;
        sz = model_q.size();
        chk("empty", int'(empty), (sz == 0) ? 1 : 0);
        chk("count", int'(count), sz);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("query_down", int'(query_down), int'(m_qd));
        chk("dout", int'(dout), (sz == 0) ? 0 : int'(model_q[0]));

        if (ev) tog = ~tog;
        ps2_key    = {tog, data};
        rd         = r_rd;
        ovf_clr    = clr;
        query_code = qc;
        reset      = rst;

        if (rst) begin
            model_q.delete();
            foreach (m_bm[i]) m_bm[i] = 1'b0;
            m_ovf = 1'b0;
            m_qd  = 1'b0;
        end else begin
            m_qd = m_bm[qc];
            full = (sz == DEPTH);
            pop  = r_rd && (sz > 0);
            if (pop) exp_q.push_back(model_q.pop_front());
            if (ev) begin
                if (!full || pop) model_q.push_back(data);
                else              m_ovf = 1'b1;
                m_bm[{data[8], data[7:0]}] = data[9];
            end
            if (!(ev && full && !pop) && clr) m_ovf = 1'b0;
        end
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        logic [7:0] codes [8];
        codes = '{8'h1C, 8'h75, 8'h12, 8'h5A, 8'h29, 8'h76, 8'h01, 8'hF0};

        // Reset with the strobe high; the model starts clean
        tog = 1'b1;
        ps2_key = 11'h400; rd = 0; ovf_clr = 0; query_code = 9'h000; reset = 1;
        foreach (m_bm[i]) m_bm[i] = 1'b0;
        m_ovf = 0; m_qd = 0;
        repeat (2) @(posedge clk_sys);
        #1;

        // Constant input after reset release: nothing appears
        for (int i = 0; i < 20; i++) step(0, 10'h000, 0, 0, 9'h000, 0);

        // Single press, then pop
        step(1, 10'h21C, 0, 0, 9'h01C, 0);
        step(0, 10'h21C, 0, 0, 9'h01C, 0);
        step(0, 10'h21C, 1, 0, 9'h01C, 0);
        step(0, 10'h21C, 0, 0, 9'h01C, 0);
        step(0, 10'h21C, 1, 0, 9'h01C, 0);   // pop while empty is ignored

        // Overfill with 17 events, drain 16, clear overflow
        for (int i = 1; i <= 17; i++) step(1, 10'(i), 0, 0, 9'h000, 0);
        step(0, 10'h011, 0, 0, 9'h000, 0);
        for (int i = 0; i < 16; i++) step(0, 10'h011, 1, 0, 9'h000, 0);
        step(0, 10'h011, 0, 1, 9'h000, 0);
        step(0, 10'h011, 0, 0, 9'h000, 0);

        // Full with simultaneous event and pop
        for (int i = 0; i < 16; i++) step(1, 10'h080 + 10'(i), 0, 0, 9'h000, 0);
        step(1, 10'h055, 1, 0, 9'h000, 0);
        for (int i = 0; i < 16; i++) step(0, 10'h055, 1, 0, 9'h000, 0);
        step(0, 10'h055, 0, 0, 9'h000, 0);

        // Extended press/release lookup, plus a non-extended alias that stays low
        step(1, 10'h375, 1, 0, 9'h075, 0);
        step(0, 10'h375, 1, 0, 9'h175, 0);
        step(0, 10'h375, 0, 0, 9'h175, 0);
        step(1, 10'h175, 1, 0, 9'h175, 0);
        step(0, 10'h175, 1, 0, 9'h175, 0);
        step(0, 10'h175, 0, 0, 9'h075, 0);
        step(0, 10'h175, 0, 0, 9'h075, 0);

        // Reset mid-stream with three entries and a held key
        for (int i = 0; i < 3; i++) step(1, 10'h240 + 10'(i), 0, 0, 9'h040, 0);
        step(0, 10'h242, 0, 0, 9'h040, 1);
        step(0, 10'h242, 0, 0, 9'h040, 0);
        step(1, 10'h233, 0, 0, 9'h040, 0);
        step(0, 10'h233, 0, 0, 9'h033, 0);
        step(0, 10'h233, 1, 0, 9'h033, 0);
        step(0, 10'h233, 0, 0, 9'h033, 0);

        // Randomized traffic with shifting pop pressure and a small code set
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] d;
            logic [8:0] q;
            int         rd_pct;
            rd_pct = ((i / 300) % 2 == 0) ? 20 : 70;
            d = {1'($urandom), 1'($urandom), codes[$urandom_range(7)]};
            q = {1'($urandom), codes[$urandom_range(7)]};
            step(1'($urandom_range(1)),
                 d,
                 $urandom_range(99) < rd_pct,
                 $urandom_range(99) < 5,
                 q,
                 $urandom_range(499) == 0);
        end
        for (int i = 0; i < DEPTH + 2; i++) step(0, 10'h000, 1, 0, 9'h000, 0);
        step(0, 10'h000, 0, 0, 9'h000, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
